uart_tx_arbiter: RTL

Round-robin arbiter that shares the single UART transmitter among four on-chip requesters (e.g. debug unit, MIPS memory-mapped port, status reporter, loopback echo). It sits between the requesters and the UART transmitter. It grants the transmitter one byte at a time and locks the grant for a multi-byte frame until that requester's `last` byte has been sent. An idle-frame timeout prevents a stalled requester from starving the others.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four requesters.
// A grant is locked for a whole frame and dropped on an idle timeout.
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              req,
    input  logic [4*DATA_WIDTH-1:0] data,
    input  logic [3:0]              last,
    output logic [3:0]              ack,
    output logic                    tx_start,
    output logic [DATA_WIDTH-1:0]   tx_data,
    input  logic                    tx_done,
    output logic                    grant_valid,
    output logic [1:0]              grant_id,
    output logic                    abort
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(HOLD_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [1:0]            owner_q, owner_d;
    logic                  last_q, last_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] txData_q, txData_d;
    logic                  grantValid_q, grantValid_d;
    logic [1:0]            grantId_q, grantId_d;
    logic [3:0]            ack_q, ack_d;
    logic                  txStart_q, txStart_d;
    logic                  abort_q, abort_d;

    logic [DATA_WIDTH-1:0] reqByte [4];
    logic [1:0]            searchIdx;
    logic [1:0]            winner;
    logic                  winnerFound;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            reqByte[i] = data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan from the far end back towards ptr so the closest requester wins.
    always_comb begin
        searchIdx   = ptr_q;
        winner      = ptr_q;
        winnerFound = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            searchIdx = ptr_q + 2'(i);
            if (req[searchIdx]) begin
                winner      = searchIdx;
                winnerFound = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        txData_d     = txData_q;
        grantValid_d = grantValid_q;
        grantId_d    = grantId_q;
        ack_d        = 4'b0000;
        txStart_d    = 1'b0;
        abort_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (winnerFound) begin
                    txData_d     = reqByte[winner];
                    last_d       = last[winner];
                    owner_d      = winner;
                    grantId_d    = winner;
                    grantValid_d = 1'b1;
                    txStart_d    = 1'b1;
                    ack_d        = 4'b0001 << winner;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (tx_done) begin
                    if (last_q) begin
                        ptr_d        = owner_q + 2'd1;
                        grantValid_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Other requesters stay blocked until the owner finishes or times out.
                if (req[owner_q]) begin
                    txData_d  = reqByte[owner_q];
                    last_d    = last[owner_q];
                    txStart_d = 1'b1;
                    ack_d     = 4'b0001 << owner_q;
                    state_d   = BUSY;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    abort_d      = 1'b1;
                    ptr_d        = owner_q + 2'd1;
                    grantValid_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= 2'd0;
            owner_q      <= 2'd0;
            last_q       <= 1'b0;
            cnt_q        <= 16'd0;
            txData_q     <= '0;
            grantValid_q <= 1'b0;
            grantId_q    <= 2'd0;
            ack_q        <= 4'b0000;
            txStart_q    <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            txData_q     <= txData_d;
            grantValid_q <= grantValid_d;
            grantId_q    <= grantId_d;
            ack_q        <= ack_d;
            txStart_q    <= txStart_d;
            abort_q      <= abort_d;
        end
    end

    assign ack         = ack_q;
    assign tx_start    = txStart_q;
    assign tx_data     = txData_q;
    assign grant_valid = grantValid_q;
    assign grant_id    = grantId_q;
    assign abort       = abort_q;

endmodule
